// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: flop-based tag/valid/dirty store in front of an
// external 1024 x 128-bit line array, with one outstanding write-back or refill to memory at a time.
module cache_ctrl #(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic               cpu_req_rw,
    input  logic [31:0]        cpu_req_addr,
    input  logic [31:0]        cpu_req_data,
    output logic               cpu_res_ready,
    output logic [31:0]        cpu_res_data,
    output logic               mem_req_valid,
    output logic               mem_req_rw,
    output logic [31:0]        mem_req_addr,
    output logic [127:0]       mem_req_data,
    input  logic               mem_res_ready,
    input  logic [127:0]       mem_res_data,
    output logic [INDEX_W-1:0] data_index,
    output logic               data_we,
    output logic [127:0]       data_write,
    input  logic [127:0]       data_read
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
    state_t state, state_next;

    logic [LINES-1:0]   valid_bits;
    logic [LINES-1:0]   dirty_bits;
    logic [TAG_W-1:0]   tag_mem [LINES];

    logic               req_rw;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_word;
    logic [31:0]        req_data;

    logic               hit;
    logic               victim_dirty;
    logic               accept;
    logic               write_hit;
    logic               read_hit;
    logic               refill_done;
    logic [TAG_W-1:0]   victim_tag;
    logic               unused_addr_bits;

    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] w);
        return line[32*w +: 32];
    endfunction

    function automatic logic [127:0] word_merge(input logic [127:0] line, input logic [1:0] w,
                                                input logic [31:0] d);
        logic [127:0] r;
        r = line;
        r[32*w +: 32] = d;
        return r;
    endfunction

    assign unused_addr_bits = ^cpu_req_addr[1:0];

    assign victim_tag    = tag_mem[req_index];
    assign hit           = valid_bits[req_index] && (victim_tag == req_tag);
    assign victim_dirty  = valid_bits[req_index] && dirty_bits[req_index];
    assign cpu_req_ready = (state == IDLE) && !rst;
    assign accept        = cpu_req_valid && cpu_req_ready;
    assign write_hit     = (state == COMPARE) && hit && req_rw && !rst;
    assign read_hit      = (state == COMPARE) && hit && !req_rw;
    // A refill landing in the same cycle as rst is abandoned, never written.
    assign refill_done   = (state == ALLOCATE) && mem_res_ready && !rst;

    assign data_index = (state == IDLE) ? cpu_req_addr[INDEX_W+3:4] : req_index;
    assign data_we    = write_hit || refill_done;
    assign data_write = (state == ALLOCATE) ? mem_res_data : word_merge(data_read, req_word, req_data);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept) state_next = COMPARE;
            COMPARE: begin
                if (hit)               state_next = IDLE;
                else if (victim_dirty) state_next = WRITE_BACK;
                else                   state_next = ALLOCATE;
            end
            WRITE_BACK: if (mem_res_ready) state_next = ALLOCATE;
            ALLOCATE:   if (mem_res_ready) state_next = COMPARE;
            default:    state_next = IDLE;
        endcase
    end

    // Memory request fields derive only from latched request state and the held index,
    // so they stay stable for the whole time mem_req_valid is high.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        if (!rst) begin
            case (state)
                WRITE_BACK: begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = 1'b1;
                    mem_req_addr  = {victim_tag, req_index, 4'h0};
                    mem_req_data  = data_read;
                end
                ALLOCATE: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {req_tag, req_index, 4'h0};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid_bits    <= '0;
            dirty_bits    <= '0;
            cpu_res_ready <= 1'b0;
            cpu_res_data  <= '0;
        end else begin
            state         <= state_next;
            cpu_res_ready <= (state == COMPARE) && hit;
            if (read_hit)  cpu_res_data <= word_sel(data_read, req_word);
            if (write_hit) dirty_bits[req_index] <= 1'b1;
            if (refill_done) begin
                valid_bits[req_index] <= 1'b1;
                dirty_bits[req_index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_rw    <= cpu_req_rw;
            req_tag   <= cpu_req_addr[31:INDEX_W+4];
            req_index <= cpu_req_addr[INDEX_W+3:4];
            req_word  <= cpu_req_addr[3:2];
            req_data  <= cpu_req_data;
        end
        if (refill_done) tag_mem[req_index] <= req_tag;
    end
endmodule
